// File: rtl/ahb_ap_sequencer_if.sv
// Interface bundling the request/response FIFO ports and the generic bus master port
// of the AHB access-point command sequencer.
// master: the sequencer side. slave: the FIFOs and the bus bridge.
interface ahb_ap_sequencer_if;
   logic        rempty;
   logic [40:0] rdata_fifo1;
   logic        rinc;
   logic        wfull;
   logic [31:0] wdata_fifo2;
   logic        winc;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ren;
   logic        wen;
   logic [3:0]  byte_en;
   logic        busy;
   logic        err;

   modport master (
      input  rempty, rdata_fifo1, wfull, rdata, busy,
      output rinc, wdata_fifo2, winc, addr, wdata, ren, wen, byte_en, err
   );

   modport slave (
      output rempty, rdata_fifo1, wfull, rdata, busy,
      input  rinc, wdata_fifo2, winc, addr, wdata, ren, wen, byte_en, err
   );
endinterface

// File: rtl/ahb_ap_sequencer.sv
// AHB access-point command sequencer. Pops 41-bit command words from the request FIFO,
// runs them one at a time on the generic bus master port and pushes read data into the
// response FIFO. Holds the AP address and CSW (byte enables, auto-increment) state.
// Optional macro AHB_AP_BUS_TIMEOUT_EN: abort bus transfers that stay busy for
// TIMEOUT_CYCLES cycles, set the sticky err flag and return 32'hBADA_CCE5 for reads.
module ahb_ap_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [3:0]  RESET_BYTE_EN  = 4'hF
) (
   input logic                CLK,
   input logic                RST,
   ahb_ap_sequencer_if.master bus
);

   localparam logic [1:0] OpSetAddr = 2'b00;
   localparam logic [1:0] OpWrite   = 2'b01;
   localparam logic [1:0] OpRead    = 2'b10;
   localparam logic [1:0] OpSetCsw  = 2'b11;

   typedef enum logic [1:0] {StIdle, StExec, StBus, StResp} state_e;

   state_e      state_q, state_d;
   logic [1:0]  op_q;
   logic [31:0] payload_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] resp_q;
   logic [3:0]  byte_en_q;
   logic        autoinc_q;
   logic        xfer_done;
   logic        xfer_timeout;
   logic        timeout_hit;
   logic        unused_bits;

`ifdef AHB_AP_BUS_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] cnt_q;
   logic            err_q;

   assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
   assign bus.err     = err_q;
   assign unused_bits = ^bus.rdata_fifo1[38:32];

   // Count consecutive busy request cycles; cleared whenever we are not on the bus.
   always_ff @(posedge CLK) begin
      if (RST || state_q != StBus) begin
         cnt_q <= '0;
      end else if (bus.busy) begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   // Sticky timeout flag, only cleared by reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         err_q <= 1'b0;
      end else if (xfer_timeout) begin
         err_q <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign bus.err     = 1'b0;
   assign unused_bits = ^{bus.rdata_fifo1[38:32], TIMEOUT_CYCLES};
`endif

   assign bus.addr        = addr_q;
   assign bus.wdata       = wdata_q;
   assign bus.byte_en     = byte_en_q;
   assign bus.wdata_fifo2 = resp_q;

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and strobes; pops/pushes are suppressed while reset is asserted.
   always_comb begin
      state_d      = state_q;
      bus.rinc     = 1'b0;
      bus.winc     = 1'b0;
      bus.ren      = 1'b0;
      bus.wen      = 1'b0;
      xfer_done    = 1'b0;
      xfer_timeout = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!bus.rempty && !RST) begin
               bus.rinc = 1'b1;
               state_d  = StExec;
            end
         end
         StExec: begin
            if (op_q == OpWrite || op_q == OpRead) begin
               state_d = StBus;
            end else begin
               state_d = StIdle;
            end
         end
         StBus: begin
            bus.ren = (op_q == OpRead);
            bus.wen = (op_q == OpWrite);
            if (!bus.busy) begin
               xfer_done = 1'b1;
            end else if (timeout_hit) begin
               xfer_timeout = 1'b1;
            end
            if (xfer_done || xfer_timeout) begin
               state_d = (op_q == OpRead) ? StResp : StIdle;
            end
         end
         StResp: begin
            if (!bus.wfull && !RST) begin
               bus.winc = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Command latch, AP address/CSW registers, write data and response capture.
   always_ff @(posedge CLK) begin
      if (RST) begin
         op_q      <= OpSetAddr;
         payload_q <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         resp_q    <= '0;
         byte_en_q <= RESET_BYTE_EN;
         autoinc_q <= 1'b0;
      end else begin
         if (bus.rinc) begin
            op_q      <= bus.rdata_fifo1[40:39];
            payload_q <= bus.rdata_fifo1[31:0];
         end
         if (state_q == StExec) begin
            unique case (op_q)
               OpSetAddr: addr_q <= payload_q;
               OpWrite:   wdata_q <= payload_q;
               OpSetCsw: begin
                  byte_en_q <= payload_q[3:0];
                  autoinc_q <= payload_q[4];
               end
               default: ;
            endcase
         end
         if (xfer_done) begin
            // Wraps modulo 2^32 by construction.
            if (autoinc_q) begin
               addr_q <= addr_q + 32'd4;
            end
            if (op_q == OpRead) begin
               resp_q <= bus.rdata;
            end
         end
         if (xfer_timeout) begin
            resp_q <= 32'hBADA_CCE5;
         end
      end
   end

endmodule

// File: tb/tb_ahb_ap_sequencer.sv
// Self-checking bench for ahb_ap_sequencer: directed test-plan steps followed by random
// commands, all checked against a command-level model of the AP registers.
module tb_ahb_ap_sequencer;

   localparam logic [1:0] OpSetAddr = 2'b00;
   localparam logic [1:0] OpWrite   = 2'b01;
   localparam logic [1:0] OpRead    = 2'b10;
   localparam logic [1:0] OpSetCsw  = 2'b11;

   logic CLK = 1'b0;
   logic RST;

   int checks = 0;
   int errors = 0;

   // Command-level model state.
   logic [31:0] m_addr;
   logic [3:0]  m_be;
   logic        m_ai;
   logic        m_err;

   ahb_ap_sequencer_if bus ();

   ahb_ap_sequencer #(
      .TIMEOUT_CYCLES(8),
      .RESET_BYTE_EN (4'hF)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ren"}, 32'(bus.ren), 0);
      chk({tag, "_wen"}, 32'(bus.wen), 0);
      chk({tag, "_winc"}, 32'(bus.winc), 0);
      chk({tag, "_addr"}, bus.addr, m_addr);
      chk({tag, "_be"}, 32'(bus.byte_en), 32'(m_be));
      chk({tag, "_err"}, 32'(bus.err), 32'(m_err));
   endtask

   // Issue one command from IDLE and follow it back to IDLE, checking every cycle.
   task automatic do_cmd(input logic [1:0] op, input logic [31:0] pl, input int busy_n,
                         input logic [31:0] rd, input int full_n);
      logic [6:0] rsvd;
      rsvd = 7'($urandom);
      bus.rempty      = 1'b0;
      bus.rdata_fifo1 = {op, rsvd, pl};
      #2;
      chk("rinc_pop", 32'(bus.rinc), 1);
      chk("winc_at_pop", 32'(bus.winc), 0);
      step();
      bus.rempty = 1'b1;
      #2;
      chk("rinc_exec", 32'(bus.rinc), 0);
      chk("bus_exec", 32'({bus.ren, bus.wen}), 0);
      if (op == OpSetAddr) begin
         m_addr = pl;
      end else if (op == OpSetCsw) begin
         m_be = pl[3:0];
         m_ai = pl[4];
      end else begin
         for (int k = 0; k <= busy_n; k++) begin
            step();
            bus.busy  = (k < busy_n);
            bus.rdata = (k < busy_n) ? $urandom : rd;
            #2;
            chk("ren_bus", 32'(bus.ren), 32'(op == OpRead));
            chk("wen_bus", 32'(bus.wen), 32'(op == OpWrite));
            chk("addr_bus", bus.addr, m_addr);
            chk("be_bus", 32'(bus.byte_en), 32'(m_be));
            if (op == OpWrite) chk("wdata_bus", bus.wdata, pl);
            chk("rinc_bus", 32'(bus.rinc), 0);
            chk("err_bus", 32'(bus.err), 32'(m_err));
         end
         if (m_ai) m_addr = m_addr + 32'd4;
         if (op == OpRead) begin
            for (int k = 0; k <= full_n; k++) begin
               step();
               bus.busy   = 1'b1;
               bus.wfull  = (k < full_n);
               bus.rempty = (k < full_n) ? 1'b0 : 1'b1;
               #2;
               chk("ren_resp", 32'(bus.ren), 0);
               chk("winc_resp", 32'(bus.winc), 32'(k == full_n));
               chk("rinc_resp", 32'(bus.rinc), 0);
               if (k == full_n) chk("resp_data", bus.wdata_fifo2, rd);
            end
         end
      end
      step();
      bus.rempty = 1'b1;
      bus.wfull  = 1'b0;
      bus.busy   = 1'b1;
      #2;
      chk_idle("idle");
   endtask

   initial begin
      RST             = 1'b1;
      bus.rempty      = 1'b1;
      bus.rdata_fifo1 = '0;
      bus.wfull       = 1'b0;
      bus.rdata       = '0;
      bus.busy        = 1'b1;
      m_addr = '0;
      m_be   = 4'hF;
      m_ai   = 1'b0;
      m_err  = 1'b0;

      // Reset values.
      step();
      step();
      #2;
      chk_idle("rst");
      chk("rst_rinc", 32'(bus.rinc), 0);
      chk("rst_wdata", bus.wdata, 0);
      chk("rst_resp", bus.wdata_fifo2, 0);
      chk("rst_addr0", bus.addr, 0);
      chk("rst_be", 32'(bus.byte_en), 32'hF);
      RST = 1'b0;

      // Auto-increment reads.
      do_cmd(OpSetCsw, 32'h0000_001F, 0, 0, 0);
      do_cmd(OpSetAddr, 32'h1000_0000, 0, 0, 0);
      do_cmd(OpRead, 32'h0, 0, 32'hA, 0);
      do_cmd(OpRead, 32'h0, 0, 32'hB, 0);
      do_cmd(OpRead, 32'h0, 0, 32'hC, 0);
      chk("autoinc_addr", bus.addr, 32'h1000_000C);

      // Write held busy five cycles, no auto-increment.
      do_cmd(OpSetCsw, 32'h0000_000F, 0, 0, 0);
      do_cmd(OpWrite, 32'hDEAD_BEEF, 5, 0, 0);
      chk("write_addr_kept", bus.addr, 32'h1000_000C);

      // Response back-pressure.
      do_cmd(OpRead, 32'h0, 1, 32'h1234_5678, 10);

      // Address wrap.
      do_cmd(OpSetCsw, 32'h0000_0013, 0, 0, 0);
      do_cmd(OpSetAddr, 32'hFFFF_FFFC, 0, 0, 0);
      do_cmd(OpWrite, 32'h5555_AAAA, 0, 0, 0);
      chk("wrap_addr", bus.addr, 32'h0);

      // Random commands.
      for (int n = 0; n < 40; n++) begin
         do_cmd(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3), $urandom,
                $urandom_range(0, 2));
      end

      // Reset during the bus phase of a read.
      bus.rempty      = 1'b0;
      bus.rdata_fifo1 = {OpRead, 7'h0, 32'h0};
      step();
      bus.rempty = 1'b1;
      step();
      bus.busy = 1'b1;
      #2;
      chk("prerst_ren", 32'(bus.ren), 1);
      RST = 1'b1;
      step();
      RST = 1'b0;
      m_addr = '0;
      m_be   = 4'hF;
      m_ai   = 1'b0;
      m_err  = 1'b0;
      #2;
      chk_idle("midrst");
      chk("midrst_addr0", bus.addr, 0);
      chk("midrst_be", 32'(bus.byte_en), 32'hF);
      for (int k = 0; k < 6; k++) begin
         step();
         bus.busy = 1'b0;
         #2;
         chk("midrst_no_winc", 32'(bus.winc), 0);
         chk("midrst_no_ren", 32'(bus.ren), 0);
      end
      bus.busy = 1'b1;

      // Stuck bus.
      do_cmd(OpSetAddr, 32'h2000_0000, 0, 0, 0);
`ifdef AHB_AP_BUS_TIMEOUT_EN
      bus.rempty      = 1'b0;
      bus.rdata_fifo1 = {OpRead, 7'h0, 32'h0};
      step();
      bus.rempty = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         bus.busy = 1'b1;
         #2;
         chk("to_ren_high", 32'(bus.ren), 1);
         chk("to_err_low", 32'(bus.err), 0);
      end
      step();
      #2;
      m_err = 1'b1;
      chk("to_ren_drop", 32'(bus.ren), 0);
      chk("to_err", 32'(bus.err), 1);
      chk("to_winc", 32'(bus.winc), 1);
      chk("to_resp", bus.wdata_fifo2, 32'hBADA_CCE5);
      step();
      #2;
      chk_idle("to_idle");
`else
      do_cmd(OpRead, 32'h0, 12, 32'h0BAD_F00D, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_ap_sequencer.md
Name: ahb_ap_sequencer

Overview:
- Command sequencer for the AHB access point. Pops 41-bit command words from the request FIFO and executes each one on the generic bus master port.
- Returns read data as 32-bit words into the response FIFO.
- Sits between the JTAG-clock-domain FIFOs (system-side ports) and the generic-bus-to-AHB bridge. Holds the AP's address and control (CSW) state.

Parameters:
- TIMEOUT_CYCLES, 256: bus cycles a transfer may stay busy before abort. Used only with the optional feature.
- RESET_BYTE_EN, 4'hF: reset value of the byte-enable CSW field.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- rempty  in  1  request FIFO empty; rdata_fifo1 is valid (show-ahead) when 0
- rdata_fifo1  in  41  request word: [40:39] op, [38:32] reserved (ignored), [31:0] payload
- rinc  out  1  request FIFO pop strobe
- wfull  in  1  response FIFO full
- wdata_fifo2  out  32  response word
- winc  out  1  response FIFO push strobe
- addr  out  32  bus address
- wdata  out  32  bus write data
- rdata  in  32  bus read data, valid on the cycle busy=0 while ren=1
- ren  out  1  bus read request
- wen  out  1  bus write request
- byte_en  out  4  bus byte enables
- busy  in  1  bus busy; a transfer completes on the first cycle ren|wen=1 and busy=0
- err  out  1  sticky timeout flag; tied 0 without the optional feature

Behaviour:
- Reset (RST=1 at a CLK edge) values:
  - state=IDLE; rinc=winc=ren=wen=0
  - addr reg=0; wdata reg=0; wdata_fifo2=0
  - byte_en reg=RESET_BYTE_EN; autoinc=0; err=0
- Reset mid-operation: the in-flight command and any pending response are dropped. Strobes are low from the cycle after the reset edge. No partial push or pop occurs.
- Opcodes:
  - 00 SET_ADDR: addr<=payload.
  - 01 WRITE: bus write of payload to addr.
  - 10 READ: bus read of addr, result pushed to the response FIFO.
  - 11 SET_CSW: byte_en<=payload[3:0], autoinc<=payload[4]. payload[31:5] ignored.
- IDLE:
  - If rempty=0: rinc=1 (combinational, exactly one cycle), latch the command, go to EXEC.
  - Otherwise hold.
- EXEC (1 cycle):
  - SET_ADDR/SET_CSW: update registers, go to IDLE. Total 2 cycles per config command.
  - WRITE: wdata<=payload, go to BUS.
  - READ: go to BUS.
- BUS:
  - ren (READ) or wen (WRITE) held high, with addr, wdata and byte_en stable, until busy=0 is sampled.
  - On completion:
    - Deassert ren/wen next cycle.
    - If autoinc=1: addr<=addr+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
    - WRITE: go to IDLE.
    - READ: capture rdata into the response register, go to RESP.
  - A busy=0 response on the first request cycle gives a single-cycle transfer.
- RESP:
  - If wfull=0: winc=1 for one cycle, wdata_fifo2=response, go to IDLE.
  - If wfull=1: hold (back-pressure). No further request pops occur while in RESP.
- Ordering and strobes:
  - Commands execute strictly in FIFO order, one outstanding at a time.
  - rinc and winc are never high in the same cycle.
  - ren and wen are never both high.
- Latency (busy=0 immediately, FIFOs ready):
  - READ: pop -> push = 4 cycles (IDLE, EXEC, BUS, RESP).
  - WRITE: 3 cycles.
- rinc is never asserted when rempty=1. winc is never asserted when wfull=1.

Optional Feature:
- Macro: AHB_AP_BUS_TIMEOUT_EN.
- Defined:
  - A counter runs while in BUS. If busy stays 1 for TIMEOUT_CYCLES consecutive request cycles, ren/wen drop and err<=1 (sticky until RST).
  - READ pushes 32'hBADA_CCE5 via RESP. WRITE returns to IDLE.
  - addr is not incremented on timeout.
- Undefined: no counter; BUS waits indefinitely; err tied 0.

Test Plan:
- SET_CSW payload 0x1F, then SET_ADDR 0x1000_0000, then three READs with busy=0 and rdata 0xA,0xB,0xC -> bus addrs 0x1000_0000/04/08, byte_en=4'hF, FIFO2 receives 0xA,0xB,0xC in order.
- WRITE 0xDEAD_BEEF with busy held 5 cycles -> wen high 6 cycles with stable addr and wdata, one rinc total, no winc, addr unchanged (autoinc=0).
- READ with wfull=1 for 10 cycles -> winc stays 0, no further rinc though rempty=0; wfull drops -> single winc carrying the read data.
- autoinc=1, addr=0xFFFF_FFFC, WRITE -> addr wraps to 0x0000_0000.
- RST asserted during BUS of a READ -> next cycle ren=0, no winc ever for that command, addr=0, byte_en=4'hF.
- With AHB_AP_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, READ with busy stuck at 1 -> ren drops after 8 cycles, err=1, FIFO2 receives 0xBADA_CCE5. Without the macro, ren stays high and err=0.
